// File: rtl/dm_arbiter.sv
// Two-port sequencer in front of a registered-read data memory.
// Each access walks IDLE -> ISSUE -> RESP; arbitration is round-robin or port-0 priority with a starvation guard.
module dm_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int P0_PRIORITY = 0,
  parameter int MAX_WAIT    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt_id
);
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] W_MAX = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t          r_state;
  logic [WCW-1:0]  r_wait;
  logic            r_gnt;
  logic            r_ack0;
  logic            r_ack1;
  logic            r_we;
  logic            r_busy;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;

  logic            w_tie;
  logic            w_win;

  // Winner is only meaningful when at least one port is requesting.
  always_comb begin
    w_tie = p0_req & p1_req;
    w_win = p1_req;
    if (w_tie) begin
      if (P0_PRIORITY == 0) w_win = ~r_gnt;
      else                  w_win = (r_wait == W_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_gnt   <= 1'b1;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (p0_req | p1_req) begin
            r_gnt   <= w_win;
            r_we    <= w_win ? p1_we    : p0_we;
            r_addr  <= w_win ? p1_addr  : p0_addr;
            r_wdata <= w_win ? p1_wdata : p0_wdata;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
            // Guard counts only port-0 wins over a waiting port 1; saturates.
            if (w_win)
              r_wait <= '0;
            else if (w_tie && (P0_PRIORITY != 0) && (r_wait != W_MAX))
              r_wait <= r_wait + 1'b1;
          end
        end
        ISSUE: begin
          r_we    <= 1'b0;
          r_ack0  <= ~r_gnt;
          r_ack1  <= r_gnt;
          r_state <= RESP;
        end
        RESP: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign p0_ack    = r_ack0;
  assign p1_ack    = r_ack1;
  assign p0_rdata  = r_ack0 ? mem_rdata : '0;
  assign p1_rdata  = r_ack1 ? mem_rdata : '0;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;
  assign gnt_id    = r_gnt;
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a round-robin and a fixed-priority instance, each with its own memory,
// checked every cycle against a transaction-level model plus hand-computed expectations.
module tb_dm_arbiter;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        p0_req[2], p0_we[2], p1_req[2], p1_we[2];
  logic [15:0] p0_addr[2], p0_wdata[2], p1_addr[2], p1_wdata[2];
  logic [15:0] mem_rdata[2];
  wire         p0_ack[2], p1_ack[2], mem_we[2], busy[2], gnt_id[2];
  wire  [15:0] p0_rdata[2], p1_rdata[2], mem_addr[2], mem_wdata[2];

  dm_arbiter #(.AW(16), .DW(16), .P0_PRIORITY(0), .MAX_WAIT(MW)) u_rr (
    .clk(clk), .rst(rst[0]),
    .p0_req(p0_req[0]), .p0_we(p0_we[0]), .p0_addr(p0_addr[0]), .p0_wdata(p0_wdata[0]),
    .p0_ack(p0_ack[0]), .p0_rdata(p0_rdata[0]),
    .p1_req(p1_req[0]), .p1_we(p1_we[0]), .p1_addr(p1_addr[0]), .p1_wdata(p1_wdata[0]),
    .p1_ack(p1_ack[0]), .p1_rdata(p1_rdata[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0]), .gnt_id(gnt_id[0]));

  dm_arbiter #(.AW(16), .DW(16), .P0_PRIORITY(1), .MAX_WAIT(MW)) u_fp (
    .clk(clk), .rst(rst[1]),
    .p0_req(p0_req[1]), .p0_we(p0_we[1]), .p0_addr(p0_addr[1]), .p0_wdata(p0_wdata[1]),
    .p0_ack(p0_ack[1]), .p0_rdata(p0_rdata[1]),
    .p1_req(p1_req[1]), .p1_we(p1_we[1]), .p1_addr(p1_addr[1]), .p1_wdata(p1_wdata[1]),
    .p1_ack(p1_ack[1]), .p1_rdata(p1_rdata[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1]), .gnt_id(gnt_id[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h expected %h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memories behind each instance: registered read, write when mem_we.
  logic [15:0] mem[2][65536];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_we[k]) mem[k][mem_addr[k]] <= mem_wdata[k];
      mem_rdata[k] <= mem[k][mem_addr[k]];
    end
  end

  // Transaction model: age 0 = free, 1 = address phase, 2 = response phase of the granted access.
  int          age[2], waitc[2];
  logic        mg[2], mwe[2];
  logic [15:0] maddr[2], mwd[2], mrd[2];
  logic [15:0] shadow[2][65536];
  bit          chk_en[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic tie, win;
      if (age[k] == 1 && mwe[k]) shadow[k][maddr[k]] = mwd[k];
      if (rst[k]) begin
        age[k] = 0; mg[k] = 1'b1; mwe[k] = 1'b0; maddr[k] = '0; mwd[k] = '0; waitc[k] = 0;
        chk_en[k] = 1'b1;
      end else if (age[k] == 0) begin
        if (p0_req[k] || p1_req[k]) begin
          tie = p0_req[k] && p1_req[k];
          if (!tie)        win = p1_req[k];
          else if (k == 0) win = !mg[k];
          else             win = (waitc[k] == MW);
          if (win) waitc[k] = 0;
          else if (tie && k == 1 && waitc[k] < MW) waitc[k] = waitc[k] + 1;
          mg[k]    = win;
          mwe[k]   = win ? p1_we[k]    : p0_we[k];
          maddr[k] = win ? p1_addr[k]  : p0_addr[k];
          mwd[k]   = win ? p1_wdata[k] : p0_wdata[k];
          age[k]   = 1;
        end
      end else if (age[k] == 1) begin
        mrd[k] = shadow[k][maddr[k]];
        age[k] = 2;
      end else begin
        age[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (chk_en[k]) begin
        chk("busy",   k, 16'(busy[k]),   16'(age[k] != 0));
        chk("gnt_id", k, 16'(gnt_id[k]), 16'(mg[k]));
        chk("mem_we", k, 16'(mem_we[k]), 16'(age[k] == 1 && mwe[k]));
        chk("mem_addr",  k, mem_addr[k],  maddr[k]);
        chk("mem_wdata", k, mem_wdata[k], mwd[k]);
        chk("p0_ack", k, 16'(p0_ack[k]), 16'(age[k] == 2 && !mg[k]));
        chk("p1_ack", k, 16'(p1_ack[k]), 16'(age[k] == 2 && mg[k]));
        if (!(age[k] == 2 && !mg[k])) chk("p0_rdata_idle", k, p0_rdata[k], 16'h0);
        else if (!mwe[k])             chk("p0_rdata", k, p0_rdata[k], mrd[k]);
        if (!(age[k] == 2 && mg[k]))  chk("p1_rdata_idle", k, p1_rdata[k], 16'h0);
        else if (!mwe[k])             chk("p1_rdata", k, p1_rdata[k], mrd[k]);
      end
    end
  end

  // Event counters used by the literal expectations.
  int          wecnt[2], ack0cnt[2], ack1cnt[2];
  logic [15:0] we_addr[2], we_data[2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_we[k]) begin wecnt[k]++; we_addr[k] = mem_addr[k]; we_data[k] = mem_wdata[k]; end
      if (p0_ack[k]) ack0cnt[k]++;
      if (p1_ack[k]) ack1cnt[k]++;
    end
  end

  task automatic pulse_rst(input int k, input int n);
    rst[k] = 1'b1;
    repeat (n) @(negedge clk);
    rst[k] = 1'b0;
  endtask

  // Single access from one port; returns latency from request to ack and the returned data.
  task automatic access(input int k, input bit port, input bit we, input logic [15:0] a,
                        input logic [15:0] d, output int lat, output logic [15:0] rd);
    int c0;
    @(negedge clk);
    if (port) begin p1_req[k] = 1; p1_we[k] = we; p1_addr[k] = a; p1_wdata[k] = d; end
    else      begin p0_req[k] = 1; p0_we[k] = we; p0_addr[k] = a; p0_wdata[k] = d; end
    c0 = cyc; lat = -1; rd = 'x;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (port ? p1_ack[k] : p0_ack[k]) begin
        lat = cyc - c0;
        rd  = port ? p1_rdata[k] : p0_rdata[k];
        break;
      end
    end
    p0_req[k] = 0; p1_req[k] = 0;
    if (lat < 0) chk("access_timeout", k, 16'hDEAD, 16'h0);
  endtask

  // Both ports hold read requests until n acks are seen; records grant order and ack cycles.
  task automatic both(input int k, input int n, output int ord[$], output int at[$]);
    ord = {}; at = {};
    @(negedge clk);
    p0_req[k] = 1; p0_we[k] = 0; p0_addr[k] = 16'h0001;
    p1_req[k] = 1; p1_we[k] = 0; p1_addr[k] = 16'h0002;
    for (int i = 0; i < 80 && ord.size() < n; i++) begin
      @(negedge clk);
      if (p0_ack[k]) begin ord.push_back(0); at.push_back(cyc); end
      if (p1_ack[k]) begin ord.push_back(1); at.push_back(cyc); end
    end
    p0_req[k] = 0; p1_req[k] = 0;
    if (ord.size() < n) chk("both_timeout", k, 16'(ord.size()), 16'(n));
  endtask

  initial begin
    int lat, ord[$], at[$], c0, ta, tb, w0, a0;
    logic [15:0] rd;
    int exp_fp[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 65536; a++) begin mem[k][a] = '0; shadow[k][a] = '0; end
      rst[k] = 1; p0_req[k] = 0; p1_req[k] = 0; p0_we[k] = 0; p1_we[k] = 0;
      p0_addr[k] = '0; p1_addr[k] = '0; p0_wdata[k] = '0; p1_wdata[k] = '0;
      age[k] = 0; waitc[k] = 0; mg[k] = 1; mwe[k] = 0; maddr[k] = '0; mwd[k] = '0; mrd[k] = '0;
      chk_en[k] = 0; wecnt[k] = 0; ack0cnt[k] = 0; ack1cnt[k] = 0;
    end
    repeat (2) @(negedge clk);
    rst[0] = 0; rst[1] = 0;
    chk("reset_gnt", 0, 16'(gnt_id[0]), 16'h1);
    chk("reset_busy", 1, 16'(busy[1]), 16'h0);

    // Reset held two cycles starting in the response phase.
    @(negedge clk);
    p0_req[0] = 1; p0_we[0] = 0; p0_addr[0] = 16'h0005;
    repeat (2) @(negedge clk);
    chk("resp_ack_before_rst", 0, 16'(p0_ack[0]), 16'h1);
    p0_req[0] = 0;
    pulse_rst(0, 2);
    chk("post_rst_gnt", 0, 16'(gnt_id[0]), 16'h1);
    chk("post_rst_busy", 0, 16'(busy[0]), 16'h0);
    chk("post_rst_addr", 0, mem_addr[0], 16'h0);
    a0 = ack0cnt[0] + ack1cnt[0];
    repeat (4) @(negedge clk);
    chk("no_ack_after_rst", 0, 16'(ack0cnt[0] + ack1cnt[0]), 16'(a0));

    // Write then read back through port 0.
    w0 = wecnt[0];
    access(0, 0, 1, 16'h0010, 16'hBEEF, lat, rd);
    chk("wr_latency", 0, 16'(lat), 16'd2);
    chk("wr_we_cycles", 0, 16'(wecnt[0] - w0), 16'd1);
    access(0, 0, 0, 16'h0010, 16'h0000, lat, rd);
    chk("rd_latency", 0, 16'(lat), 16'd2);
    chk("rd_data", 0, rd, 16'hBEEF);

    // Round-robin under continuous contention.
    pulse_rst(0, 1);
    both(0, 4, ord, at);
    for (int i = 0; i < 4; i++) if (i < ord.size()) chk("rr_order", 0, 16'(ord[i]), 16'(i % 2));
    for (int i = 1; i < 4; i++) if (i < at.size()) chk("rr_spacing", 0, 16'(at[i] - at[i-1]), 16'd3);

    // Port 1 raised during the address phase of a port-0 access waits for the next round.
    @(negedge clk);
    p0_req[0] = 1; p0_we[0] = 0; p0_addr[0] = 16'h0010;
    c0 = cyc; ta = -1; tb = -1;
    @(negedge clk);
    p1_req[0] = 1; p1_we[0] = 0; p1_addr[0] = 16'h0002;
    for (int i = 0; i < 20 && tb < 0; i++) begin
      @(negedge clk);
      if (p0_ack[0]) begin ta = cyc; p0_req[0] = 0; end
      if (p1_ack[0]) begin tb = cyc; p1_req[0] = 0; end
    end
    p0_req[0] = 0; p1_req[0] = 0;
    chk("late_p0_latency", 0, 16'(ta - c0), 16'd2);
    chk("late_p1_gap", 0, 16'(tb - ta), 16'd3);

    // Fixed priority with the starvation guard.
    pulse_rst(1, 1);
    both(1, 10, ord, at);
    for (int i = 0; i < 10; i++) if (i < ord.size()) chk("fp_order", 1, 16'(ord[i]), 16'(exp_fp[i]));

    // Port-1 write at the top address, then read it back.
    a0 = ack0cnt[1]; w0 = wecnt[1];
    access(1, 1, 1, 16'hFFFF, 16'hFFFF, lat, rd);
    chk("p1_wr_latency", 1, 16'(lat), 16'd2);
    chk("p1_wr_we_cycles", 1, 16'(wecnt[1] - w0), 16'd1);
    chk("p1_wr_addr", 1, we_addr[1], 16'hFFFF);
    chk("p1_wr_data", 1, we_data[1], 16'hFFFF);
    chk("p1_wr_no_p0_ack", 1, 16'(ack0cnt[1] - a0), 16'd0);
    access(1, 1, 0, 16'hFFFF, 16'h0000, lat, rd);
    chk("p1_rd_data", 1, rd, 16'hFFFF);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
